// File: rtl/mem_sorter.sv
// mem_sorter: in-place bubble sort over a single-port synchronous BRAM.
// The engine is the only initiator on the memory port. Reads have one cycle
// of latency, so each compare step is RD0/RD1/CMP/ADV, with WR0/WR1 inserted
// when the pair must be swapped.
// Build option: define MEM_SORTER_DESCENDING_EN to sort in descending order.
//
// state | meaning
// IDLE  | waiting for i_start, memory port quiet
// RD0   | present address i
// RD1   | present address i+1, capture mem[i] into a
// CMP   | capture mem[i+1] into b, decide swap
// WR0   | write b to address i
// WR1   | write a to address i+1, mark pass as swapped
// ADV   | next pair, next pass, or finish
// DONE  | one-cycle completion pulse
module mem_sorter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_di,
  input  logic [DATA_WIDTH-1:0] i_mem_do
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_WR0  = 3'd4;
  localparam logic [2:0] S_WR1  = 3'd5;
  localparam logic [2:0] S_ADV  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  // Last index of the array (N-1); also the compare count of the first pass.
  localparam logic [ADDR_WIDTH-1:0] LP_LIM_INIT = '1;
  localparam logic [ADDR_WIDTH-1:0] LP_ONE      = ADDR_WIDTH'(1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_i;
  logic [ADDR_WIDTH-1:0] r_lim;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_swapped;

  logic                  w_swap;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_i_nxt;
  logic [ADDR_WIDTH-1:0] w_lim_m1;

  assign w_i_nxt  = r_i + LP_ONE;
  assign w_lim_m1 = r_lim - LP_ONE;

  // b is taken straight from the read port so the decision does not wait for r_b.
`ifdef MEM_SORTER_DESCENDING_EN
  assign w_swap = (r_a < i_mem_do);
`else
  assign w_swap = (r_a > i_mem_do);
`endif

  // Sequencer: walks pairs, shrinks the pass limit, stops early on a clean pass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_lim     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_i       <= '0;
            r_lim     <= LP_LIM_INIT;
            r_swapped <= 1'b0;
            r_state   <= S_RD0;
          end
        end
        S_RD0: r_state <= S_RD1;
        S_RD1: begin
          r_a     <= i_mem_do;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_b     <= i_mem_do;
          r_state <= w_swap ? S_WR0 : S_ADV;
        end
        S_WR0: r_state <= S_WR1;
        S_WR1: begin
          r_swapped <= 1'b1;
          r_state   <= S_ADV;
        end
        S_ADV: begin
          if (r_i < w_lim_m1) begin
            r_i     <= w_i_nxt;
            r_state <= S_RD0;
          end else if (!r_swapped || (r_lim == LP_ONE)) begin
            r_state <= S_DONE;
          end else begin
            r_lim     <= w_lim_m1;
            r_i       <= '0;
            r_swapped <= 1'b0;
            r_state   <= S_RD0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory port and status outputs decoded from the registered state.
  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    w_we       = 1'b0;
    o_mem_addr = '0;
    o_mem_di   = '0;
    case (r_state)
      S_RD0: begin
        o_busy     = 1'b1;
        o_mem_addr = r_i;
      end
      S_RD1, S_CMP: begin
        o_busy     = 1'b1;
        o_mem_addr = w_i_nxt;
      end
      S_WR0: begin
        o_busy     = 1'b1;
        w_we       = 1'b1;
        o_mem_addr = r_i;
        o_mem_di   = r_b;
      end
      S_WR1: begin
        o_busy     = 1'b1;
        w_we       = 1'b1;
        o_mem_addr = w_i_nxt;
        o_mem_di   = r_a;
      end
      S_ADV: begin
        o_busy     = 1'b1;
        o_mem_addr = r_i;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // A reset edge must never also be a write edge.
  assign o_mem_we = w_we & ~i_rst;

endmodule

// File: doc/mem_sorter.md
# mem_sorter

In-place bubble-sort engine that acts as the sole initiator on a single-port synchronous BRAM port (write-enable, address, write data, registered read data). On `start` it sorts all 2^ADDR_WIDTH entries into ascending unsigned order by reading pairs, comparing and writing back swapped pairs, then pulses `done`. It sits between the top-level control (button/start logic) and the memory array of the `memory_sort` design.

## Interface
- `ADDR_WIDTH`, 3, address width; depth N = 2^ADDR_WIDTH entries (N ≥ 2).
- `DATA_WIDTH`, 4, entry width; compared as unsigned.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sort; sampled only in IDLE.
- `busy`  out  1  high while a sort is in progress.
- `done`  out  1  one-cycle pulse when a sort completes.
- `mem_we`  out  1  BRAM write enable.
- `mem_addr`  out  ADDR_WIDTH  BRAM address.
- `mem_di`  out  DATA_WIDTH  BRAM write data.
- `mem_do`  in  DATA_WIDTH  BRAM read data; valid the cycle after an address is presented with `mem_we`=0.

## Operation
- Registers: state, index `i`, pass limit `lim` (compares per pass), `a`, `b`, `swapped` flag.
- IDLE: `mem_we`=0, `mem_addr`=0, `mem_di`=0, `busy`=0. `start`=1 → `i`=0, `lim`=N-1, `swapped`=0, go RD0.
- RD0: `mem_addr`=i, `mem_we`=0 → RD1.
- RD1: `mem_addr`=i+1, `mem_we`=0; latch `a`←`mem_do` (= mem[i]) → CMP.
- CMP: `mem_addr`=i+1, `mem_we`=0; latch `b`←`mem_do` (= mem[i+1]). If `a` > `b` → WR0, else → ADV. Compare uses `mem_do` directly for `b`.
- WR0: `mem_we`=1, `mem_addr`=i, `mem_di`=b → WR1.
- WR1: `mem_we`=1, `mem_addr`=i+1, `mem_di`=a; `swapped`←1 → ADV.
- ADV: `mem_we`=0. If `i` < `lim`-1: `i`++ → RD0. Else (end of pass): if `swapped`=0 or `lim`=1 → DONE; else `lim`--, `i`=0, `swapped`=0 → RD0.
- DONE: `done`=1, `busy`=0, `mem_we`=0 → IDLE.
- `busy`=1 in RD0, RD1, CMP, WR0, WR1, ADV.
- Equal entries never swapped (stable, no write).
- `start` while busy or in DONE: ignored, no queuing.
- Entries outside the sort are never touched; every write targets i or i+1 with i+1 ≤ lim ≤ N-1 (no address wrap).

## Timing
- All outputs are decoded from registered state; `mem_we` additionally gated by `~rst`, so no write occurs on an edge where `rst`=1.
- Reset values: state IDLE, `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0; `i`,`lim`,`a`,`b`,`swapped` cleared.
- Reset mid-operation: sort aborted at the next edge; memory left with whatever swaps completed (each WR0/WR1 pair may be split — accepted).
- Compare step: 4 cycles without swap, 6 with swap.
- Start at edge E → state RD0 in cycle E+1; `done` high exactly one cycle.
- Already sorted, N=8: one pass, 7×4 = 28 cycles, `done` in cycle E+29.
- Reverse sorted, N=8: 28 compares all swap, 168 cycles, `done` in cycle E+169.
- `start` held high continuously: new sort starts the cycle after DONE (IDLE re-samples it).

## Configuration
- `MEM_SORTER_DESCENDING_EN`: defined → swap condition becomes `a` < `b`, producing descending order; not defined → ascending order (`a` > `b`). Timing and all other behaviour identical.

## Test plan
- Bench BRAM model: 8×4, write when we, else registered read (one-cycle latency); preload via file.
- Preload 7,3,5,1,6,2,4,0, pulse `start` → memory 0,1,2,3,4,5,6,7; `done` one cycle; `busy` low afterward.
- Preload 0..7 ascending → no `mem_we` pulses at all; `done` in cycle E+29.
- Preload 7..0 descending → 56 write cycles; `done` in cycle E+169; final 0..7.
- Preload 5,5,2,2,9,9,0,0 (with 9 as 4'h9) → 0,0,2,2,5,5,9,9; no write issued for equal pairs; `start` pulsed mid-sort has no effect.
- Assert `rst` one cycle during WR0 of a swap → no write on reset edge, `busy`=0 next cycle, subsequent `start` completes a correct sort; with `MEM_SORTER_DESCENDING_EN` the first preload yields 7,6,5,4,3,2,1,0.
